// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path and datapath:
// FSM states, opcodes, mux select codes and the decoded control word.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [1:0] {
        ALUB_REG    = 2'b00,
        ALUB_FOUR   = 2'b01,
        ALUB_IMM    = 2'b10,
        ALUB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_src_t    pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

endpackage

// File: rtl/control_outdec.sv
// Combinational control-word decode from the current state; mem_ready only
// qualifies the FETCH register writes, opcode only flags illegal ops in DECODE.
module control_outdec
    import multicycle_control_pkg::*;
(
    input  state_t      state,
    input  logic        mem_ready,
    input  logic [5:0]  opcode,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = ALUB_IMM_SH;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !op_legal(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state sequencing;
// the control word itself comes from control_outdec.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_source,
    output logic           illegal_op,
    output logic [SW-1:0]  state
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_dec, ctrl;
    logic [5:0] op;
    logic       unused_zero;

    assign op = 6'(opcode);
    // The branch decision is made in the datapath (pc_write_cond & zero).
    assign unused_zero = zero;

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    control_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (op),
        .ctrl      (ctrl_dec)
    );

    // clr masks the FETCH decode so no write strobe leaks while in reset.
    assign ctrl = clr ? '0 : ctrl_dec;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = SW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state and
// control word are queued at drive time and compared on the falling edge.
module tb_multicycle_control;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SWOP = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JOP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] RTY  = 6'b000000;
    localparam logic [5:0] JUNK = 6'b111111;

    logic       clk = 1'b0;
    logic       clr, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [16:0] obs;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [16:0] outs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_control #(.OPW(6), .SW(4)) dut (
        .clk           (clk),
        .clr           (clr),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control word from the state table, same bit order as obs.
    function automatic logic [16:0] spec_outs(input logic [3:0] st, input logic r,
                                              input logic [5:0] op, input logic c);
        logic pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        if (!c) begin
            case (st)
                4'd0:  begin mr = 1; asb = 2'b01; pcw = r; irw = r; end
                4'd1:  begin asb = 2'b11;
                             ill = !(op inside {RTY, LW, SWOP, BEQ, JOP, ADDI}); end
                4'd2:  begin asa = 1; asb = 2'b10; end
                4'd3:  begin mr = 1; iord = 1; end
                4'd4:  begin rw = 1; m2r = 1; end
                4'd5:  begin mw = 1; iord = 1; end
                4'd6:  begin asa = 1; aop = 2'b10; end
                4'd7:  begin rw = 1; rd = 1; end
                4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
                4'd9:  begin pcw = 1; pcs = 2'b10; end
                4'd10: begin asa = 1; asb = 2'b10; end
                4'd11: begin rw = 1; end
                default: ;
            endcase
        end
        return {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, ill};
    endfunction

    // Drive one cycle's inputs and queue the state/outputs expected for it.
    task automatic cyc(input string tag, input logic [3:0] st, input logic r,
                       input logic [5:0] op, input logic z, input logic c);
        exp_t e;
        clr = c; mem_ready = r; opcode = op; zero = z;
        e.tag = tag; e.st = st; e.outs = spec_outs(st, r, op, c);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "/state"}, 32'(state), 32'(e.st));
            check({e.tag, "/outs"}, 32'(obs), 32'(e.outs));
        end
    end

    initial begin
        clr = 1'b1; mem_ready = 1'b1; opcode = RTY; zero = 1'b0;
        @(posedge clk); #1;

        cyc("rst", 0, 0, JUNK, 0, 1);
        cyc("rst", 0, 1, LW,   0, 1);

        cyc("lw", 0, 1, JUNK, 0, 0);
        cyc("lw", 1, 1, LW,   0, 0);
        cyc("lw", 2, 1, LW,   0, 0);
        cyc("lw", 3, 1, JUNK, 0, 0);
        cyc("lw", 4, 1, JUNK, 0, 0);

        cyc("sw", 0, 1, JUNK, 0, 0);
        cyc("sw", 1, 1, SWOP, 0, 0);
        cyc("sw", 2, 1, SWOP, 0, 0);
        cyc("sw", 5, 0, JUNK, 0, 0);
        cyc("sw", 5, 0, JUNK, 0, 0);
        cyc("sw", 5, 1, JUNK, 0, 0);

        cyc("beq", 0, 1, BEQ, 1, 0);
        cyc("beq", 1, 1, BEQ, 1, 0);
        cyc("beq", 8, 1, BEQ, 1, 0);

        cyc("j", 0, 1, JOP, 0, 0);
        cyc("j", 1, 1, JOP, 0, 0);
        cyc("j", 9, 1, JOP, 0, 0);

        cyc("stall", 0, 0, ADDI, 0, 0);
        cyc("stall", 0, 0, ADDI, 0, 0);
        cyc("stall", 0, 0, ADDI, 0, 0);
        cyc("stall", 0, 1, ADDI, 0, 0);
        cyc("addi",  1, 1, ADDI, 0, 0);
        cyc("addi", 10, 1, JUNK, 0, 0);
        cyc("addi", 11, 1, JUNK, 0, 0);

        cyc("ill", 0, 1, JUNK, 0, 0);
        cyc("ill", 1, 1, JUNK, 0, 0);

        cyc("r", 0, 1, RTY, 0, 0);
        cyc("r", 1, 1, RTY, 0, 0);
        cyc("r", 6, 1, JUNK, 0, 0);
        cyc("r", 7, 1, JUNK, 0, 0);

        cyc("clr", 0, 1, RTY, 0, 0);
        cyc("clr", 1, 1, RTY, 0, 0);
        check("pre_clr_exec", 32'(state), 32'd6);
        cyc("clr_exec", 0, 0, RTY, 0, 1);
        cyc("clr_hold", 0, 1, RTY, 0, 1);
        cyc("rel", 0, 1, JOP, 0, 0);
        cyc("rel", 1, 1, JOP, 0, 0);
        cyc("rel", 9, 1, JOP, 0, 0);
        cyc("rel", 0, 0, JUNK, 0, 0);

        @(negedge clk); #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
